clock_domain_export: RTL and testbench
======================================

// Module: clock_domain_export
//
// PURPOSE
// Source end of the toggle req/ack clock-domain crossing. Words pushed by local
// logic queue in a small FIFO and are sent one at a time to a receiver in
// another clock domain. Per word: drive handshake_data, toggle handshake_req,
// then wait until the synchronised handshake_ack equals handshake_req.
//
// PARAMETERS
// SIZE   8  width of each transferred word
// DEPTH  4  FIFO entries; power of two, >= 2
//
// PORTS
// clk             in   1      local clock
// rst_n           in   1      asynchronous reset, active low
// data            in   SIZE   word to export
// stb             in   1      push data this cycle
// ready           out  1      FIFO not full; stb accepted only when high
// busy            out  1      FIFO non-empty or a transfer in flight
// handshake_data  out  SIZE   to receiver; stable while req != ack
// handshake_req   out  1      toggles once per word
// handshake_ack   in   1      from receiver domain, asynchronous to clk
// overflow        out  1      only with CLOCK_DOMAIN_EXPORT_OVERFLOW_EN
//
// BEHAVIOUR
// - Reset (async, rst_n=0): handshake_req=0, handshake_data=0, sync flops=0,
//   FIFO empty, state IDLE, ready=1, busy=0, overflow=0.
// - ack synchroniser: 2 flops, ack_s = handshake_ack delayed 2 clk cycles.
//   handshake_ack is used only through ack_s.
// - FIFO: rd/wr pointers are log2(DEPTH)+1 bits; wrap is by natural overflow.
//   full = MSBs differ and the rest are equal. ready = !full, from registers only.
// - Push: stb && ready writes data at wr_ptr, wr_ptr++.
//   stb && !ready drops the word; the FIFO is unchanged.
// - FSM:
//   IDLE : if FIFO non-empty and ack_s == req, then handshake_data <= head,
//          rd_ptr++, go to SETUP.
//   SETUP: handshake_req <= ~handshake_req, go to WAIT. This keeps data stable
//          one cycle before req toggles.
//   WAIT : when ack_s == handshake_req, go to IDLE.
// - Simultaneous push and pop in IDLE: both take effect. ready for that cycle
//   still reflects the pre-pop count, so a full FIFO refuses the push.
// - Latency: stb into an empty idle FIFO gives a req toggle 3 cycles later
//   (write, IDLE load, SETUP). Minimum per word is 3 cycles plus 2 sync cycles
//   plus the receiver round-trip.
// - busy = FIFO non-empty || state != IDLE.
// - Reset mid-transfer drops queued and in-flight words. The receiver must be
//   reset in the same event: after reset req=0, and a stale ack=1 would
//   otherwise be read as one spurious completed transfer.
//
// CONFIGURATION
// CLOCK_DOMAIN_EXPORT_OVERFLOW_EN
// - defined: overflow is a sticky output, set the cycle after stb && !ready,
//   and cleared only by rst_n.
// - undefined: no overflow port and no sticky flag; dropped words are silent.
//
// TESTING
// 1 Reset: rst_n=0 mid-WAIT -> req=0, ready=1, busy=0 at once, without waiting
//   for a clock edge.
// 2 Single word: push 8'hA5 with ack looped back through 2 flops of a
//   slow-clock model -> data=A5 one cycle before req 0->1; req holds until
//   ack=1; busy drops after.
// 3 Burst: push 8'h01..8'h04 back-to-back, DEPTH=4 -> ready stays 1; receiver
//   gets 01,02,03,04 in order with one req toggle each.
// 4 Full: hold ack constant and push 6 words -> ready=0 after 4 writes plus
//   one in flight; extras are dropped; overflow=1 with macro defined.
// 5 Wrap: stream 20 words (0x00..0x13) at random ack delays of 1..7 cycles ->
//   all delivered in order across pointer wrap, with no loss while stb is
//   gated by ready.
// 6 Stability: assert handshake_data never changes while
//   handshake_req != ack_s.

Source files
------------

// File: rtl/clock_domain_export.sv
`default_nettype none
// ============================================================================
// Module      : clock_domain_export
// Description : Source end of a toggle req/ack clock-domain crossing.
//               Words pushed by local logic are queued in a small FIFO and
//               sent one at a time to a receiver in another clock domain.
//               For each word, handshake_data is loaded first, handshake_req
//               toggles one cycle later, and the word is complete once the
//               synchronised acknowledge matches handshake_req again.
// Options     : CLOCK_DOMAIN_EXPORT_OVERFLOW_EN adds a sticky overflow output
//               that is set when a push is refused because the FIFO is full.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_domain_export #(
    parameter int SIZE  = 8,   // width of each transferred word
    parameter int DEPTH = 4    // FIFO entries, power of two, >= 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [SIZE-1:0] data,
    input  logic            stb,
    output logic            ready,
    output logic            busy,
    output logic [SIZE-1:0] handshake_data,
    output logic            handshake_req,
    input  logic            handshake_ack
`ifdef CLOCK_DOMAIN_EXPORT_OVERFLOW_EN
    ,
    output logic            overflow
`endif
);

    // ------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------
    // Pointers carry one extra bit so that full and empty can be told
    // apart when the index bits are equal.
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // ------------------------------------------------------------------
    // Transfer state machine encoding
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // waiting for a queued word and a settled link
        ST_SETUP = 2'd1,   // data loaded, req toggles on the next edge
        ST_WAIT  = 2'd2    // req toggled, waiting for the matching ack
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    // ------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------
    logic            r_ack_meta;      // first synchroniser stage
    logic            r_ack_s;         // synchronised acknowledge
    logic [SIZE-1:0] r_mem [DEPTH];   // FIFO storage
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [SIZE-1:0] r_data;          // word presented to the receiver
    logic            r_req;           // toggle request line

    logic            w_full;
    logic            w_empty;
    logic            w_push;          // accepted write this cycle
    logic            w_load;          // FSM pops the head into r_data
    logic            w_toggle;        // FSM flips the request line
    logic            w_link_idle;     // receiver has caught up with r_req
    logic [SIZE-1:0] w_head;

    // ------------------------------------------------------------------
    // FIFO status, all derived from registers only
    // ------------------------------------------------------------------
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // A push that coincides with a pop is still judged against the
    // pre-pop occupancy, so a full FIFO refuses it.
    assign w_push  = stb && !w_full;
    assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

    // The receiver has consumed the last toggle once its synchronised
    // acknowledge equals the current request level.
    assign w_link_idle = (r_ack_s == r_req);

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ready          = !w_full;
    assign busy           = !w_empty || (r_state != ST_IDLE);
    assign handshake_data = r_data;
    assign handshake_req  = r_req;

    // Two-flop synchroniser bringing the foreign-domain acknowledge in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack_meta <= 1'b0;
            r_ack_s    <= 1'b0;
        end else begin
            r_ack_meta <= handshake_ack;
            r_ack_s    <= r_ack_meta;
        end
    end

    // FIFO storage write; contents need no reset since the pointers gate reads.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= data;
        end
    end

    // FIFO pointers; wrap happens by natural overflow of the extra bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_load) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    // State register for the transfer sequencer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and control decode for the transfer sequencer.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_toggle     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Only start a new word once the previous toggle has been
                // acknowledged; after reset both levels are zero.
                if (!w_empty && w_link_idle) begin
                    w_load       = 1'b1;
                    w_state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                // Data was registered last edge, so it is already stable
                // at the receiver before the request edge arrives.
                w_toggle     = 1'b1;
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_link_idle) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Data and request lines presented to the receiver domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_req  <= 1'b0;
        end else begin
            if (w_load) begin
                r_data <= w_head;
            end
            if (w_toggle) begin
                r_req <= ~r_req;
            end
        end
    end

`ifdef CLOCK_DOMAIN_EXPORT_OVERFLOW_EN
    logic r_overflow;

    // Sticky record of any refused push; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (stb && w_full) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow = r_overflow;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clock_domain_export.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_clock_domain_export
// Description : Self-checking bench for clock_domain_export. A queue-based
//               model predicts the source outputs every cycle, a receiver
//               model closes the req/ack loop with configurable delay, and
//               directed sequences check reset, single word, burst, full,
//               and pointer wrap behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_domain_export;
    localparam int SIZE  = 8;
    localparam int DEPTH = 4;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic [SIZE-1:0] data  = '0;
    logic            stb   = 1'b0;
    logic            ready;
    logic            busy;
    logic [SIZE-1:0] handshake_data;
    logic            handshake_req;
    logic            handshake_ack = 1'b0;
`ifdef CLOCK_DOMAIN_EXPORT_OVERFLOW_EN
    logic            overflow;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clock_domain_export #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data           (data),
        .stb            (stb),
        .ready          (ready),
        .busy           (busy),
        .handshake_data (handshake_data),
        .handshake_req  (handshake_req),
        .handshake_ack  (handshake_ack)
`ifdef CLOCK_DOMAIN_EXPORT_OVERFLOW_EN
        ,
        .overflow       (overflow)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Receiver model: runs on the falling edge so ack never moves at a
    // sampling edge; synchronises req through two stages, captures the word
    // on a new request level, then answers after a programmable delay.
    // ------------------------------------------------------------------
    logic            rx_s1, rx_s2, rx_pending;
    int              rx_cnt;
    logic            rx_freeze = 1'b0;
    int              rx_dmin = 1;
    int              rx_dmax = 1;
    logic [SIZE-1:0] rx_q[$];

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1 = 1'b0; rx_s2 = 1'b0; rx_pending = 1'b0; rx_cnt = 0;
            handshake_ack = 1'b0;
        end else begin
            rx_s2 = rx_s1;
            rx_s1 = handshake_req;
            if (rx_pending) begin
                if (rx_cnt <= 1) begin
                    handshake_ack = rx_s2;
                    rx_pending = 1'b0;
                end else begin
                    rx_cnt--;
                end
            end else if (!rx_freeze && rx_s2 != handshake_ack) begin
                rx_q.push_back(handshake_data);
                rx_pending = 1'b1;
                rx_cnt = int'($urandom_range(rx_dmax, rx_dmin));
            end
        end
    end

    // ------------------------------------------------------------------
    // Behavioural model of the source: a word queue plus a single word in
    // flight. Loading a word costs one edge, the request edge follows on
    // the next, and completion is seen once the twice-delayed ack matches.
    // ------------------------------------------------------------------
    logic [SIZE-1:0] mq[$];
    logic [SIZE-1:0] m_data;
    logic            m_req, m_inflight, m_toggle_due, m_ack_m, m_ack_s, m_ovf, m_push;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_data = '0; m_req = 1'b0; m_inflight = 1'b0; m_toggle_due = 1'b0;
            m_ack_m = 1'b0; m_ack_s = 1'b0; m_ovf = 1'b0; m_push = 1'b0;
        end else begin
            m_push = stb && (mq.size() < DEPTH);
            if (stb && !m_push) m_ovf = 1'b1;
            if (m_toggle_due) begin
                m_req = ~m_req;
                m_toggle_due = 1'b0;
            end else if (m_inflight) begin
                if (m_ack_s == m_req) m_inflight = 1'b0;
            end else if (mq.size() > 0 && m_ack_s == m_req) begin
                m_data = mq.pop_front();
                m_inflight = 1'b1;
                m_toggle_due = 1'b1;
            end
            if (m_push) mq.push_back(data);
            m_ack_s = m_ack_m;
            m_ack_m = handshake_ack;
        end
    end

    // Per-cycle comparison of DUT outputs against the model, plus data
    // stability whenever the request is outstanding.
    logic [SIZE-1:0] prev_data;
    logic            prev_open = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_open = 1'b0;
        end else begin
            check("model_req",   32'(handshake_req),  32'(m_req));
            check("model_data",  32'(handshake_data), 32'(m_data));
            check("model_ready", 32'(ready),          32'(mq.size() < DEPTH));
            check("model_busy",  32'(busy),           32'(mq.size() > 0 || m_inflight));
`ifdef CLOCK_DOMAIN_EXPORT_OVERFLOW_EN
            check("model_overflow", 32'(overflow), 32'(m_ovf));
`endif
            if (prev_open) check("data_stable", 32'(handshake_data), 32'(prev_data));
            prev_data = handshake_data;
            prev_open = (handshake_req != m_ack_s);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [SIZE-1:0] v);
        data = v;
        stb  = 1'b1;
        tick();
        stb  = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy || rx_pending || handshake_req != handshake_ack) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL wait_idle: still busy after %0d cycles", budget);
        end
    endtask

    initial begin
        // Reset state
        tick(); tick(); tick();
        check("rst_req",   32'(handshake_req),  32'h0);
        check("rst_ready", 32'(ready),          32'h1);
        check("rst_busy",  32'(busy),           32'h0);
        check("rst_data",  32'(handshake_data), 32'h0);
        rst_n = 1'b1;
        tick();

        // Asynchronous reset while a word waits for its ack
        rx_freeze = 1'b1;
        push(8'h5A);
        tick(); tick(); tick();
        check("t1_req_before", 32'(handshake_req), 32'h1);
        check("t1_busy_before", 32'(busy), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("t1_req",   32'(handshake_req), 32'h0);
        check("t1_ready", 32'(ready),         32'h1);
        check("t1_busy",  32'(busy),          32'h0);
        rx_freeze = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        rx_q.delete();
        tick();

        // Single word: data settles one cycle before req rises
        rx_dmin = 3; rx_dmax = 3;
        push(8'hA5);
        check("t2_req_after_write", 32'(handshake_req), 32'h0);
        tick();
        check("t2_data_loaded", 32'(handshake_data), 32'hA5);
        check("t2_req_still_0", 32'(handshake_req),  32'h0);
        tick();
        check("t2_req_toggled", 32'(handshake_req),  32'h1);
        wait_idle(100);
        check("t2_busy_done", 32'(busy), 32'h0);
        check("t2_rx_count", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() > 0) check("t2_rx_word", 32'(rx_q[0]), 32'hA5);

        // Burst of four back-to-back words
        rx_q.delete();
        rx_dmin = 2; rx_dmax = 2;
        for (int i = 1; i <= 4; i++) begin
            check("t3_ready", 32'(ready), 32'h1);
            push(SIZE'(i));
        end
        wait_idle(300);
        check("t3_rx_count", 32'(rx_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < rx_q.size(); i++) check("t3_rx_word", 32'(rx_q[i]), 32'(i + 1));

        // Full FIFO with ack held: four stored, one in flight, one dropped
        rx_q.delete();
        rx_freeze = 1'b1;
        for (int i = 0; i < 6; i++) push(SIZE'(8'h10 + i));
        check("t4_ready", 32'(ready), 32'h0);
        check("t4_busy",  32'(busy),  32'h1);
`ifdef CLOCK_DOMAIN_EXPORT_OVERFLOW_EN
        check("t4_overflow", 32'(overflow), 32'h1);
`endif
        rx_freeze = 1'b0;
        wait_idle(500);
        check("t4_rx_count", 32'(rx_q.size()), 32'd5);
        for (int i = 0; i < 5 && i < rx_q.size(); i++) check("t4_rx_word", 32'(rx_q[i]), 32'(8'h10 + i));
        check("t4_ready_after", 32'(ready), 32'h1);

        // Stream across pointer wrap with random ack delays
        rx_q.delete();
        rx_dmin = 1; rx_dmax = 7;
        for (int i = 0; i < 20; i++) begin
            int n = 0;
            while (!ready && n < 200) begin
                tick();
                n++;
            end
            checks++;
            if (n >= 200) begin
                errors++;
                $display("FAIL t5_ready_wait: ready low for %0d cycles", n);
            end
            push(SIZE'(i));
        end
        wait_idle(2000);
        check("t5_rx_count", 32'(rx_q.size()), 32'd20);
        for (int i = 0; i < 20 && i < rx_q.size(); i++) check("t5_rx_word", 32'(rx_q[i]), 32'(i));

        tick(); tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
